sec_tick_timekeeper: RTL and testbench
======================================

// Module: sec_tick_timekeeper
// PURPOSE
//  Consumes the slow 1 Hz square wave made by the divider and keeps watch time.
//  The wave is asynchronous to clk.
//  Brings it into the clk domain and detects its rising edge as a 1-cycle seconds tick.
//  Keeps BCD seconds/minutes/hours (24 h) with a set mode, and flags loss of the seconds source.
//  Feeds the display mux and alarm compare logic.
// PARAMETERS
//  SYNC_STAGES  2            synchroniser depth on sec_in (>=2)
//  TIMEOUT_CYC  150_000_000  clk cycles with no sec_in rising edge before sec_lost asserts
//  CNT_W        28           width of watchdog counter (must hold TIMEOUT_CYC)
// PORTS
//  clk          in   1  system clock, 100 MHz
//  rst_n        in   1  asynchronous active-low reset
//  sec_in       in   1  1 Hz square wave from the divider, async to clk
//  set_en       in   1  level: 1 = time-set mode
//  set_min_inc  in   1  1-cycle pulse, already debounced: minute +1 (set mode only)
//  set_hr_inc   in   1  1-cycle pulse, already debounced: hour +1 (set mode only)
//  tick         out  1  1-cycle pulse per detected sec_in rising edge
//  sec_bcd      out  8  seconds, {tens,units} BCD, 00..59
//  min_bcd      out  8  minutes, BCD, 00..59
//  hr_bcd       out  8  hours, BCD, 00..23
//  min_roll     out  1  1-cycle pulse when seconds wrap 59->00 during counting
//  sec_lost     out  1  level: no sec_in edge seen within TIMEOUT_CYC cycles
// BEHAVIOUR
//  Reset (async, rst_n=0): sync chain=0, edge reg=0, tick=0, all BCD=8'h00, min_roll=0,
//   sec_lost=0, watchdog count=0. The output values hold until the first clk edge after rst_n rises.
//  Edge detect: s = last sync stage; tick <= s & ~s_d. tick asserts SYNC_STAGES+1 clk
//   edges after the first edge that samples sec_in=1. tick is never high two cycles running.
//  Counting (set_en=0), on the edge where tick=1:
//   sec units 9->0 carries into tens; sec 59->00 carries into minutes and pulses min_roll.
//   Minutes 59->00 carries into hours. Hours 23->00. No carry out of hours.
//   All carries settle in the same edge: 23:59:59 -> 00:00:00 in one cycle.
//  Set mode (set_en=1):
//   - Ticks do not advance time and min_roll stays 0. tick still pulses.
//   - sec_bcd is forced to 00 on every cycle while set_en=1.
//   - set_min_inc: minutes +1 mod 60, no carry into hours.
//   - set_hr_inc: hours +1 mod 24.
//   - Both pulses in the same cycle: both apply independently.
//  set_min_inc and set_hr_inc are ignored when set_en=0.
//  Leaving set mode: counting resumes on the next tick from hh:mm:00.
//   A tick that coincides with the set_en 1->0 edge is ignored.
//  Watchdog: the counter clears on tick. Otherwise it increments, saturating at TIMEOUT_CYC.
//   sec_lost <= (count == TIMEOUT_CYC-1) | sec_lost. sec_lost clears on the next tick.
//   Time is never advanced by the watchdog.
//  BCD digits never take values A-F. Illegal states cannot be entered: there is no load path.
// STRUCTURE
//  Shared package watch_pkg: localparams SEC_MAX=8'h59, MIN_MAX=8'h59, HR_MAX=8'h23;
//   a bcd_inc function (8-bit BCD +1 with a wrap limit, returning the carry).
//  Sub-module sync_edge_det (params SYNC_STAGES): async in -> synced level + rising pulse.
//   It is reused later for button inputs.
//  Top level: edge detector, time registers with carry chain, watchdog counter.
// TESTING
//  1 Reset mid-count at 12:34:56, then release -> all BCD 00, tick=0, sec_lost=0.
//  2 sec_in with a 1000-clk period (TB time scale), 60 rising edges from 00:00:00
//    -> exactly 60 tick pulses, sec_bcd ends 00, min_bcd=01, one min_roll pulse.
//  3 Preload to 23:59:59 via set mode plus 59 ticks, then one tick
//    -> 00:00:00 in a single cycle, min_roll=1 for that cycle.
//  4 set_en=1, 61 set_min_inc pulses, 25 set_hr_inc pulses, ticks running
//    -> min 01, hr 01, sec 00, min_roll never 1.
//  5 TIMEOUT_CYC=200, hold sec_in=0 -> sec_lost rises at cycle 200 after the last tick;
//    the next tick clears it, and time advances by exactly 1 s.
//  6 sec_in glitch high for 1 clk -> at most one tick. sec_in rising on the set_en 1->0
//    cycle -> no advance.

Source files
------------

// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the watch time-keeping blocks: BCD wrap limits and a
// BCD increment helper that reports the carry out of the wrapping digit pair.
// -----------------------------------------------------------------------------
package watch_pkg;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  typedef struct packed {
    logic       carry;  // value wrapped from max back to 00
    logic [7:0] val;    // incremented {tens,units} BCD value
  } bcd_inc_t;

  // Two-digit BCD +1 that wraps to 00 after max. Inputs are assumed legal BCD
  // in 00..max, which holds because the time registers have no load path.
  function automatic bcd_inc_t bcd_inc(input logic [7:0] v, input logic [7:0] max);
    bcd_inc_t r;
    r.carry = 1'b0;
    r.val   = v;
    if (v == max) begin
      r.val   = 8'h00;
      r.carry = 1'b1;
    end else if (v[3:0] == 4'd9) begin
      r.val = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r.val = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level into the clk domain through a flop chain and
// produces a registered one-cycle pulse on each synchronised rising edge.
// Also used for push-button inputs.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   i_async  in   level asynchronous to clk
//   o_level  out  synchronised level (last chain stage)
//   o_rise   out  1-cycle pulse, SYNC_STAGES+1 edges after the first edge
//                 that samples i_async=1
// -----------------------------------------------------------------------------
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;
  logic                   r_rise;

  // NOTE: every sequential register is written with <= so all flops in the
  // chain sample the previous-cycle values; blocking here would collapse it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_level_d <= r_sync[SYNC_STAGES-1];
      // Registered pulse: high for one cycle, never two in a row, because
      // r_level_d follows the level one cycle behind.
      r_rise    <= r_sync[SYNC_STAGES-1] & ~r_level_d;
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_rise;

endmodule

// File: rtl/sec_tick_timekeeper.sv
// -----------------------------------------------------------------------------
// sec_tick_timekeeper
// Turns the asynchronous 1 Hz square wave into a seconds tick and keeps a
// 24-hour BCD hh:mm:ss with a time-set mode and a lost-source watchdog.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   sec_in       in   1 Hz square wave, asynchronous to clk
//   set_en       in   level, 1 = time-set mode (seconds held at 00)
//   set_min_inc  in   1-cycle pulse, minute +1 mod 60 in set mode
//   set_hr_inc   in   1-cycle pulse, hour +1 mod 24 in set mode
//   tick         out  1-cycle pulse per synchronised sec_in rising edge
//   sec_bcd      out  seconds BCD 00..59
//   min_bcd      out  minutes BCD 00..59
//   hr_bcd       out  hours BCD 00..23
//   min_roll     out  1-cycle pulse when seconds wrap 59->00 while counting
//   sec_lost     out  level, no tick seen for TIMEOUT_CYC cycles
// -----------------------------------------------------------------------------
module sec_tick_timekeeper
  import watch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 150_000_000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_in,
  input  logic       set_en,
  input  logic       set_min_inc,
  input  logic       set_hr_inc,
  output logic       tick,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       min_roll,
  output logic       sec_lost
);

  localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam int               HIST_W  = SYNC_STAGES + 2;

  logic             w_tick;
  logic [7:0]       r_sec, r_min, r_hr;
  logic             r_min_roll;
  logic [HIST_W-1:0] r_set_hist;
  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_sec_lost;

  logic [7:0]       w_sec_nxt, w_min_nxt, w_hr_nxt;
  logic             w_roll_nxt;
  logic             w_advance;
  bcd_inc_t         w_sec_inc, w_min_inc, w_hr_inc;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sec_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(sec_in),
    .o_level(),
    .o_rise (w_tick)
  );

  assign w_sec_inc = bcd_inc(r_sec, SEC_MAX);
  assign w_min_inc = bcd_inc(r_min, MIN_MAX);
  assign w_hr_inc  = bcd_inc(r_hr,  HR_MAX);

  // A tick reaching the counters was launched by a sec_in sample taken up to
  // SYNC_STAGES+1 cycles earlier. Holding off while set_en was high anywhere in
  // that window discards any tick coinciding with the set_en 1->0 edge, so
  // counting resumes from hh:mm:00 only on a tick seen wholly outside set mode.
  assign w_advance = w_tick & ~set_en & ~(|r_set_hist);

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_sec_nxt  = r_sec;
    w_min_nxt  = r_min;
    w_hr_nxt   = r_hr;
    w_roll_nxt = 1'b0;
    if (set_en) begin
      w_sec_nxt = 8'h00;
      if (set_min_inc) w_min_nxt = w_min_inc.val;  // no carry into hours
      if (set_hr_inc)  w_hr_nxt  = w_hr_inc.val;
    end else if (w_advance) begin
      w_sec_nxt = w_sec_inc.val;
      if (w_sec_inc.carry) begin
        w_roll_nxt = 1'b1;
        w_min_nxt  = w_min_inc.val;
        if (w_min_inc.carry) w_hr_nxt = w_hr_inc.val;  // 23->00, no carry out
      end
    end
  end

  // NOTE: all state here is plain flops, so every register takes a reset value
  // on the async reset; nothing is left to power-up state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec      <= 8'h00;
      r_min      <= 8'h00;
      r_hr       <= 8'h00;
      r_min_roll <= 1'b0;
      r_set_hist <= '0;
    end else begin
      r_sec      <= w_sec_nxt;
      r_min      <= w_min_nxt;
      r_hr       <= w_hr_nxt;
      r_min_roll <= w_roll_nxt;
      r_set_hist <= {r_set_hist[HIST_W-2:0], set_en};
    end
  end

  // Watchdog: counts cycles since the last tick, saturating so it never wraps
  // back through WD_LAST; sec_lost is sticky until the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt   <= '0;
      r_sec_lost <= 1'b0;
    end else if (w_tick) begin
      r_wd_cnt   <= '0;
      r_sec_lost <= 1'b0;
    end else begin
      if (r_wd_cnt != WD_MAX) r_wd_cnt <= r_wd_cnt + 1'b1;
      if (r_wd_cnt == WD_LAST) r_sec_lost <= 1'b1;
    end
  end

  assign tick     = w_tick;
  assign sec_bcd  = r_sec;
  assign min_bcd  = r_min;
  assign hr_bcd   = r_hr;
  assign min_roll = r_min_roll;
  assign sec_lost = r_sec_lost;

endmodule

// File: tb/tb_sec_tick_timekeeper.sv
// -----------------------------------------------------------------------------
// tb_sec_tick_timekeeper
// Directed bench for sec_tick_timekeeper with a short watchdog timeout.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sec_tick_timekeeper;

  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_in = 1'b0;
  logic       set_en = 1'b0;
  logic       set_min_inc = 1'b0;
  logic       set_hr_inc = 1'b0;
  logic       tick;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic       min_roll, sec_lost;

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled away from the active edge.
  int tick_cnt = 0;
  int roll_cnt = 0;
  int dbl_tick = 0;
  logic tick_prev = 1'b0;

  sec_tick_timekeeper #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(TIMEOUT),
    .CNT_W      (28)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sec_in     (sec_in),
    .set_en     (set_en),
    .set_min_inc(set_min_inc),
    .set_hr_inc (set_hr_inc),
    .tick       (tick),
    .sec_bcd    (sec_bcd),
    .min_bcd    (min_bcd),
    .hr_bcd     (hr_bcd),
    .min_roll   (min_roll),
    .sec_lost   (sec_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick === 1'b1) tick_cnt++;
    if (min_roll === 1'b1) roll_cnt++;
    if (tick === 1'b1 && tick_prev === 1'b1) dbl_tick++;
    tick_prev = tick;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    tick_cnt = 0;
    roll_cnt = 0;
    dbl_tick = 0;
  endtask

  task automatic do_reset();
    sec_in      = 1'b0;
    set_en      = 1'b0;
    set_min_inc = 1'b0;
    set_hr_inc  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    clear_counts();
  endtask

  task automatic sec_pulse(input int hi, input int lo);
    sec_in = 1'b1;
    repeat (hi) step();
    sec_in = 1'b0;
    repeat (lo) step();
  endtask

  task automatic set_time(input int h, input int m);
    set_en = 1'b1;
    step();
    repeat (h) begin set_hr_inc = 1'b1; step(); set_hr_inc = 1'b0; step(); end
    repeat (m) begin set_min_inc = 1'b1; step(); set_min_inc = 1'b0; step(); end
    set_en = 1'b0;
    repeat (6) step();
  endtask

  // Waits at negedges for tick, at most max_cyc cycles.
  task automatic wait_tick(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    set_time(12, 34);
    repeat (56) sec_pulse(10, 10);
    @(negedge clk);
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd} !== 24'h123456) begin
      errors++;
      $display("FAIL reset_precount time: got %h want 123456", {hr_bcd, min_bcd, sec_bcd});
    end
    // Assert reset asynchronously mid-cycle while a sec_in edge is in flight.
    step();
    sec_in = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd, tick, min_roll, sec_lost} !== 27'd0) begin
      errors++;
      $display("FAIL reset_async outputs: got %h want 0", {hr_bcd, min_bcd, sec_bcd, tick, min_roll, sec_lost});
    end
    sec_in = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd, tick, min_roll, sec_lost} !== 27'd0) begin
      errors++;
      $display("FAIL reset_release outputs: got %h want 0", {hr_bcd, min_bcd, sec_bcd, tick, min_roll, sec_lost});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_minute_count();
    do_reset();
    repeat (60) sec_pulse(500, 500);
    repeat (5) step();
    checks++;
    if (tick_cnt !== 60) begin
      errors++;
      $display("FAIL minute_ticks: got %0d want 60", tick_cnt);
    end
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd} !== 24'h000100) begin
      errors++;
      $display("FAIL minute_time: got %h want 000100", {hr_bcd, min_bcd, sec_bcd});
    end
    checks++;
    if (roll_cnt !== 1) begin
      errors++;
      $display("FAIL minute_roll_count: got %0d want 1", roll_cnt);
    end
    checks++;
    if (dbl_tick !== 0) begin
      errors++;
      $display("FAIL minute_double_tick: got %0d want 0", dbl_tick);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_day_wrap();
    bit seen;
    do_reset();
    set_time(23, 59);
    repeat (59) sec_pulse(10, 10);
    @(negedge clk);
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd} !== 24'h235959) begin
      errors++;
      $display("FAIL wrap_preload: got %h want 235959", {hr_bcd, min_bcd, sec_bcd});
    end
    step();
    sec_in = 1'b1;
    wait_tick(10, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wrap_tick_timeout: got no tick want tick within 10 cycles");
    end
    @(negedge clk);
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd, min_roll} !== {24'h000000, 1'b1}) begin
      errors++;
      $display("FAIL wrap_single_cycle: got %h roll=%b want 000000 roll=1", {hr_bcd, min_bcd, sec_bcd}, min_roll);
    end
    @(negedge clk);
    checks++;
    if (min_roll !== 1'b0) begin
      errors++;
      $display("FAIL wrap_roll_width: got %b want 0", min_roll);
    end
    sec_in = 1'b0;
    repeat (5) step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_set_mode();
    int ticks_before;
    do_reset();
    repeat (3) sec_pulse(10, 10);
    set_en = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (sec_bcd !== 8'h00) begin
      errors++;
      $display("FAIL set_sec_forced: got %h want 00", sec_bcd);
    end
    clear_counts();
    fork
      begin
        repeat (61) begin set_min_inc = 1'b1; step(); set_min_inc = 1'b0; step(); end
        repeat (25) begin set_hr_inc = 1'b1; step(); set_hr_inc = 1'b0; step(); end
      end
      begin
        repeat (8) begin
          sec_in = 1'b1;
          repeat (10) @(posedge clk);
          sec_in = 1'b0;
          repeat (10) @(posedge clk);
        end
      end
    join
    repeat (3) step();
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd} !== 24'h010100) begin
      errors++;
      $display("FAIL set_inc_wrap: got %h want 010100", {hr_bcd, min_bcd, sec_bcd});
    end
    checks++;
    if (roll_cnt !== 0 || tick_cnt !== 8) begin
      errors++;
      $display("FAIL set_ticks_roll: got ticks=%0d rolls=%0d want ticks=8 rolls=0", tick_cnt, roll_cnt);
    end
    // Both increment pulses in the same cycle apply independently.
    set_min_inc = 1'b1;
    set_hr_inc  = 1'b1;
    step();
    set_min_inc = 1'b0;
    set_hr_inc  = 1'b0;
    step();
    checks++;
    if ({hr_bcd, min_bcd} !== 16'h0202) begin
      errors++;
      $display("FAIL set_both_inc: got %h want 0202", {hr_bcd, min_bcd});
    end
    // Outside set mode the increment pulses do nothing.
    set_en = 1'b0;
    repeat (6) step();
    set_min_inc = 1'b1;
    set_hr_inc  = 1'b1;
    step();
    set_min_inc = 1'b0;
    set_hr_inc  = 1'b0;
    step();
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd} !== 24'h020200) begin
      errors++;
      $display("FAIL set_inc_ignored: got %h want 020200", {hr_bcd, min_bcd, sec_bcd});
    end
    ticks_before = tick_cnt;
    sec_pulse(10, 10);
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd} !== 24'h020201 || tick_cnt !== ticks_before + 1) begin
      errors++;
      $display("FAIL set_resume: got %h want 020201", {hr_bcd, min_bcd, sec_bcd});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_watchdog();
    bit seen;
    do_reset();
    step();
    sec_in = 1'b1;
    wait_tick(10, seen);
    sec_in = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wd_first_tick: got no tick want tick within 10 cycles");
    end
    @(posedge clk);               // edge where the watchdog clears
    repeat (TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sec_lost !== 1'b0) begin
      errors++;
      $display("FAIL wd_early: got sec_lost=%b want 0 at cycle %0d", sec_lost, TIMEOUT - 1);
    end
    @(negedge clk);
    checks++;
    if (sec_lost !== 1'b1) begin
      errors++;
      $display("FAIL wd_assert: got sec_lost=%b want 1 at cycle %0d", sec_lost, TIMEOUT);
    end
    repeat (300) step();
    checks++;
    if (sec_lost !== 1'b1 || {hr_bcd, min_bcd, sec_bcd} !== 24'h000001) begin
      errors++;
      $display("FAIL wd_hold: got lost=%b time=%h want lost=1 time=000001", sec_lost, {hr_bcd, min_bcd, sec_bcd});
    end
    sec_pulse(10, 10);
    checks++;
    if (sec_lost !== 1'b0 || {hr_bcd, min_bcd, sec_bcd} !== 24'h000002) begin
      errors++;
      $display("FAIL wd_recover: got lost=%b time=%h want lost=0 time=000002", sec_lost, {hr_bcd, min_bcd, sec_bcd});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_glitch_and_exit();
    int ticks_before;
    do_reset();
    step();
    sec_in = 1'b1;
    step();
    sec_in = 1'b0;
    repeat (10) step();
    checks++;
    if (tick_cnt > 1 || dbl_tick !== 0) begin
      errors++;
      $display("FAIL glitch_ticks: got ticks=%0d doubles=%0d want <=1 and 0", tick_cnt, dbl_tick);
    end
    checks++;
    if (sec_bcd !== 8'(tick_cnt) || {hr_bcd, min_bcd} !== 16'h0000) begin
      errors++;
      $display("FAIL glitch_time: got %h want sec=%0d", {hr_bcd, min_bcd, sec_bcd}, tick_cnt);
    end
    // sec_in rises on the same cycle set_en drops: tick pulses, time holds.
    set_en = 1'b1;
    repeat (3) step();
    ticks_before = tick_cnt;
    set_en = 1'b0;
    sec_in = 1'b1;
    repeat (10) step();
    sec_in = 1'b0;
    repeat (10) step();
    checks++;
    if (tick_cnt !== ticks_before + 1) begin
      errors++;
      $display("FAIL exit_tick_pulse: got %0d want %0d", tick_cnt, ticks_before + 1);
    end
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
      errors++;
      $display("FAIL exit_no_advance: got %h want 000000", {hr_bcd, min_bcd, sec_bcd});
    end
    sec_pulse(10, 10);
    checks++;
    if ({hr_bcd, min_bcd, sec_bcd} !== 24'h000001) begin
      errors++;
      $display("FAIL exit_resume: got %h want 000001", {hr_bcd, min_bcd, sec_bcd});
    end
  endtask

  initial begin
    test_reset();
    test_minute_count();
    test_day_wrap();
    test_set_mode();
    test_watchdog();
    test_glitch_and_exit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
